iic_eeprom_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one IIC EEPROM byte engine between two requesters. It accepts single-byte read or write requests and builds the 32-bit engine configuration word. It issues the one-cycle start pulse, waits for engine completion, and returns read data and status to the requester. After every write it enforces the EEPROM internal write-cycle time (tWR) before granting the next request.

---
 rtl/iic_eeprom_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_iic_eeprom_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_eeprom_arbiter.sv
// Round-robin arbiter and sequencer sharing one IIC EEPROM byte engine between
// two single-byte requesters, with post-write tWR blocking and a done timeout.
module iic_eeprom_arbiter #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned TWR_CYC     = 500000,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        i_req0_valid,
    input  logic        i_req0_rd,
    input  logic [7:0]  i_req0_addr,
    input  logic [7:0]  i_req0_wdat,
    output logic        o_req0_ack,
    input  logic        i_req1_valid,
    input  logic        i_req1_rd,
    input  logic [7:0]  i_req1_addr,
    input  logic [7:0]  i_req1_wdat,
    output logic        o_req1_ack,
    output logic [7:0]  o_rdat,
    output logic        o_err,
    output logic        o_busy,
    output logic [31:0] o_cfg_dat,
    output logic        o_cfg_start_en,
    input  logic        i_iic_done,
    input  logic [7:0]  i_iic_rd_dat
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESP,
        S_WR_CYCLE
    } state_t;

    state_t             r_state;
    logic               r_gnt_id;
    logic               r_rd;
    logic [31:0]        r_cfg_dat;
    logic               r_start;
    logic               r_ack0;
    logic               r_ack1;
    logic [7:0]         r_rdat;
    logic               r_err;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;
    logic               r_served;

    state_t             w_state_nxt;
    logic               w_gnt_nxt;
    logic               w_rd_nxt;
    logic [31:0]        w_cfg_nxt;
    logic               w_start_nxt;
    logic               w_ack0_nxt;
    logic               w_ack1_nxt;
    logic [7:0]         w_rdat_nxt;
    logic               w_err_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last_nxt;
    logic               w_served_nxt;

    logic               w_pick1;
    logic               w_sel_rd;
    logic [7:0]         w_sel_addr;
    logic [7:0]         w_sel_wdat;

    // On contention favour whoever was not served last; req0 until anyone has been served.
    assign w_pick1    = (i_req0_valid && i_req1_valid) ? (r_served && !r_last) : i_req1_valid;
    assign w_sel_rd   = w_pick1 ? i_req1_rd   : i_req0_rd;
    assign w_sel_addr = w_pick1 ? i_req1_addr : i_req0_addr;
    assign w_sel_wdat = w_pick1 ? i_req1_wdat : i_req0_wdat;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt_id;
        w_rd_nxt     = r_rd;
        w_cfg_nxt    = r_cfg_dat;
        w_start_nxt  = 1'b0;
        w_ack0_nxt   = 1'b0;
        w_ack1_nxt   = 1'b0;
        w_rdat_nxt   = r_rdat;
        w_err_nxt    = r_err;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_served_nxt = r_served;

        unique case (r_state)
            S_IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    w_gnt_nxt   = w_pick1;
                    w_rd_nxt    = w_sel_rd;
                    w_cfg_nxt   = {DEV_ADDR, 1'b0, w_sel_addr, DEV_ADDR, w_sel_rd,
                                   (w_sel_rd ? 8'h00 : w_sel_wdat)};
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_iic_done) begin
                    w_rdat_nxt  = r_rd ? i_iic_rd_dat : 8'h00;
                    w_err_nxt   = 1'b0;
                    w_ack0_nxt  = !r_gnt_id;
                    w_ack1_nxt  = r_gnt_id;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_rdat_nxt  = 8'h00;
                    w_err_nxt   = 1'b1;
                    w_ack0_nxt  = !r_gnt_id;
                    w_ack1_nxt  = r_gnt_id;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_last_nxt   = r_gnt_id;
                w_served_nxt = 1'b1;
                if (!r_rd && !r_err) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WR_CYCLE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_CYCLE: begin
                if (r_cnt == CNT_W'(TWR_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt_id  <= 1'b0;
            r_rd      <= 1'b0;
            r_cfg_dat <= '0;
            r_start   <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdat    <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_last    <= 1'b0;
            r_served  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_id  <= w_gnt_nxt;
            r_rd      <= w_rd_nxt;
            r_cfg_dat <= w_cfg_nxt;
            r_start   <= w_start_nxt;
            r_ack0    <= w_ack0_nxt;
            r_ack1    <= w_ack1_nxt;
            r_rdat    <= w_rdat_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_served  <= w_served_nxt;
        end
    end

    assign o_req0_ack     = r_ack0;
    assign o_req1_ack     = r_ack1;
    assign o_rdat         = r_rdat;
    assign o_err          = r_err;
    assign o_busy         = r_busy;
    assign o_cfg_dat      = r_cfg_dat;
    assign o_cfg_start_en = r_start;

endmodule

// File: tb/tb_iic_eeprom_arbiter.sv
// Directed bench for iic_eeprom_arbiter with a fixed-latency engine model
// (done 50 cycles after start, can be switched off to force a timeout).
module tb_iic_eeprom_arbiter;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        i_req0_valid, i_req0_rd;
    logic [7:0]  i_req0_addr, i_req0_wdat;
    logic        o_req0_ack;
    logic        i_req1_valid, i_req1_rd;
    logic [7:0]  i_req1_addr, i_req1_wdat;
    logic        o_req1_ack;
    logic [7:0]  o_rdat;
    logic        o_err;
    logic        o_busy;
    logic [31:0] o_cfg_dat;
    logic        o_cfg_start_en;
    logic        i_iic_done;
    logic [7:0]  i_iic_rd_dat;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_start = 0;
    int start_cyc = 0;

    logic       eng_en;
    logic [7:0] eng_cnt;

    iic_eeprom_arbiter #(
        .DEV_ADDR    (7'h50),
        .TWR_CYC     (20),
        .TIMEOUT_CYC (100)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .i_req0_valid   (i_req0_valid),
        .i_req0_rd      (i_req0_rd),
        .i_req0_addr    (i_req0_addr),
        .i_req0_wdat    (i_req0_wdat),
        .o_req0_ack     (o_req0_ack),
        .i_req1_valid   (i_req1_valid),
        .i_req1_rd      (i_req1_rd),
        .i_req1_addr    (i_req1_addr),
        .i_req1_wdat    (i_req1_wdat),
        .o_req1_ack     (o_req1_ack),
        .o_rdat         (o_rdat),
        .o_err          (o_err),
        .o_busy         (o_busy),
        .o_cfg_dat      (o_cfg_dat),
        .o_cfg_start_en (o_cfg_start_en),
        .i_iic_done     (i_iic_done),
        .i_iic_rd_dat   (i_iic_rd_dat)
    );

    always #5 sys_clk = ~sys_clk;

    // Engine model: done pulse lands 50 cycles after the cycle carrying start.
    initial begin
        eng_cnt    = 8'd0;
        i_iic_done = 1'b0;
    end
    always @(posedge sys_clk) begin
        if (o_cfg_start_en && eng_en) eng_cnt <= 8'd49;
        else if (eng_cnt != 8'd0)     eng_cnt <= eng_cnt - 8'd1;
        i_iic_done <= (eng_cnt == 8'd1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (o_cfg_start_en) begin
            n_start++;
            start_cyc = cyc;
        end
    endtask

    task automatic wait_start();
        int k = 0;
        do begin tick(); k++; end while (!o_cfg_start_en && k < 100);
        if (!o_cfg_start_en) chk("start_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_ack(output int lat, output logic a0, output logic a1);
        int k = 0;
        do begin tick(); k++; end while (!(o_req0_ack || o_req1_ack) && k < 300);
        a0  = o_req0_ack;
        a1  = o_req1_ack;
        lat = cyc - start_cyc;
        if (!(a0 || a1)) chk("ack_wait", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat;
        int          n;
        int          s0;
        int          ack_cyc;
        logic        a0, a1;
        logic [31:0] cfg_v;

        rst = 1'b1;
        eng_en = 1'b1;
        i_iic_rd_dat = 8'h00;
        i_req0_valid = 1'b0; i_req0_rd = 1'b0; i_req0_addr = 8'h00; i_req0_wdat = 8'h00;
        i_req1_valid = 1'b0; i_req1_rd = 1'b0; i_req1_addr = 8'h00; i_req1_wdat = 8'h00;
        repeat (3) tick();
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_cfg",   o_cfg_dat, 32'd0);
        chk("rst_acks",  32'({o_req0_ack, o_req1_ack, o_cfg_start_en, o_err}), 32'd0);
        chk("rst_rdat",  32'(o_rdat), 32'd0);
        rst = 1'b0;
        tick();

        // 1: req0 write 0x12 <- 0xA5
        i_req0_valid = 1'b1; i_req0_rd = 1'b0; i_req0_addr = 8'h12; i_req0_wdat = 8'hA5;
        s0 = n_start;
        wait_start();
        chk("wr_cfg",   o_cfg_dat, 32'hA012A0A5);
        chk("wr_busy0", 32'(o_busy), 32'd1);
        i_req0_valid = 1'b0;
        wait_ack(lat, a0, a1);
        chk("wr_lat",   32'(lat), 32'd51);
        chk("wr_who",   32'({a0, a1}), 32'b10);
        chk("wr_err",   32'(o_err), 32'd0);
        chk("wr_nstart", 32'(n_start - s0), 32'd1);
        tick();
        chk("wr_ack_pulse", 32'(o_req0_ack), 32'd0);
        n = 0;
        while (o_busy && n < 100) begin n++; tick(); end
        chk("wr_twr_busy", 32'(n), 32'd20);

        // 2: req1 read 0x34, engine returns 0x5C; wdat must not leak into cfg
        i_iic_rd_dat = 8'h5C;
        i_req1_valid = 1'b1; i_req1_rd = 1'b1; i_req1_addr = 8'h34; i_req1_wdat = 8'hFF;
        wait_start();
        chk("rd_cfg", o_cfg_dat, 32'hA034A100);
        i_req1_valid = 1'b0;
        wait_ack(lat, a0, a1);
        chk("rd_lat",  32'(lat), 32'd51);
        chk("rd_who",  32'({a0, a1}), 32'b01);
        chk("rd_rdat", 32'(o_rdat), 32'h5C);
        chk("rd_err",  32'(o_err), 32'd0);
        tick();
        chk("rd_no_twr", 32'(o_busy), 32'd0);

        // 3: both hold reads; last served was req1 so order is 0,1,0,1
        i_iic_rd_dat = 8'h77;
        i_req0_valid = 1'b1; i_req0_rd = 1'b1; i_req0_addr = 8'h40;
        i_req1_valid = 1'b1; i_req1_rd = 1'b1; i_req1_addr = 8'h41;
        s0 = n_start;
        for (int i = 0; i < 4; i++) begin
            wait_start();
            cfg_v = o_cfg_dat;
            chk("rr_addr", 32'(cfg_v[23:16]), (i % 2 == 1) ? 32'h41 : 32'h40);
            wait_ack(lat, a0, a1);
            chk("rr_ack", 32'({a0, a1}), (i % 2 == 1) ? 32'b01 : 32'b10);
            if (i == 3) begin
                i_req0_valid = 1'b0;
                i_req1_valid = 1'b0;
            end
        end
        chk("rr_rdat",   32'(o_rdat), 32'h77);
        chk("rr_nstart", 32'(n_start - s0), 32'd4);

        // 4: req0 write, req1 arrives during tWR and must wait it out
        i_iic_rd_dat = 8'h3B;
        i_req0_valid = 1'b1; i_req0_rd = 1'b0; i_req0_addr = 8'h55; i_req0_wdat = 8'h3C;
        wait_start();
        chk("blk_cfg0", o_cfg_dat, 32'hA055A03C);
        i_req0_valid = 1'b0;
        wait_ack(lat, a0, a1);
        ack_cyc = cyc;
        i_req1_valid = 1'b1; i_req1_rd = 1'b1; i_req1_addr = 8'h66;
        wait_start();
        chk("blk_gap",  32'(start_cyc - ack_cyc), 32'd22);
        chk("blk_cfg1", o_cfg_dat, 32'hA066A100);
        i_req1_valid = 1'b0;
        wait_ack(lat, a0, a1);
        chk("blk_who",  32'({a0, a1}), 32'b01);
        chk("blk_rdat", 32'(o_rdat), 32'h3B);
        tick();

        // 5: engine silent -> timeout on a write, no tWR afterwards
        eng_en = 1'b0;
        i_req0_valid = 1'b1; i_req0_rd = 1'b0; i_req0_addr = 8'h77; i_req0_wdat = 8'h11;
        wait_start();
        i_req0_valid = 1'b0;
        wait_ack(lat, a0, a1);
        chk("to_lat",  32'(lat == 100 || lat == 101), 32'd1);
        chk("to_who",  32'({a0, a1}), 32'b10);
        chk("to_err",  32'(o_err), 32'd1);
        chk("to_rdat", 32'(o_rdat), 32'd0);
        tick();
        chk("to_no_twr", 32'(o_busy), 32'd0);
        eng_en = 1'b1;
        i_iic_rd_dat = 8'h9E;
        i_req1_valid = 1'b1; i_req1_rd = 1'b1; i_req1_addr = 8'h88;
        wait_start();
        i_req1_valid = 1'b0;
        wait_ack(lat, a0, a1);
        chk("to_next_lat",  32'(lat), 32'd51);
        chk("to_next_rdat", 32'(o_rdat), 32'h9E);
        chk("to_next_err",  32'(o_err), 32'd0);
        tick();

        // 6: reset during WAIT_DONE; the late done must be ignored
        i_iic_rd_dat = 8'h42;
        i_req0_valid = 1'b1; i_req0_rd = 1'b1; i_req0_addr = 8'h99;
        wait_start();
        i_req0_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("mid_busy", 32'(o_busy), 32'd0);
        chk("mid_cfg",  o_cfg_dat, 32'd0);
        chk("mid_rdat", 32'(o_rdat), 32'd0);
        chk("mid_outs", 32'({o_req0_ack, o_req1_ack, o_cfg_start_en, o_err}), 32'd0);
        rst = 1'b0;
        n = 0;
        repeat (60) begin
            tick();
            if (o_req0_ack || o_req1_ack || o_busy) n++;
        end
        chk("mid_late_done", 32'(n), 32'd0);

        // After reset the rr state is cleared: req0 wins contention again
        i_req0_valid = 1'b1; i_req0_rd = 1'b1; i_req0_addr = 8'hA0;
        i_req1_valid = 1'b1; i_req1_rd = 1'b1; i_req1_addr = 8'hA1;
        wait_start();
        chk("post_rst_cfg", o_cfg_dat, 32'hA0A0A100);
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        wait_ack(lat, a0, a1);
        chk("post_rst_who",  32'({a0, a1}), 32'b10);
        chk("post_rst_rdat", 32'(o_rdat), 32'h42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
